// File: rtl/qf_rfm_mp_if.sv
// Bus bundle for the qf_rfm_mp register-file memory.
// The master side drives the write port and the read requests.
// The slave side is the memory, which returns read data, read valids and the init-busy flag.
interface qf_rfm_mp_if #(
   parameter int PAR_MEMORY_WIDTH_BIT = 64,
   parameter int PAR_MEMORY_DEPTH_BIT = 4,
   parameter int PAR_RD_PORTS         = 2,
   parameter int PAR_BYTE_WIDTH       = 8
);
   localparam int W = PAR_MEMORY_WIDTH_BIT;
   localparam int D = PAR_MEMORY_DEPTH_BIT;
   localparam int P = PAR_RD_PORTS;
   localparam int B = PAR_MEMORY_WIDTH_BIT / PAR_BYTE_WIDTH;

   logic           rfm_wr_en;
   logic [D-1:0]   rfm_wr_addr;
   logic [W-1:0]   rfm_wr_data;
   logic [B-1:0]   rfm_wr_be;
   logic [P-1:0]   rfm_rd_en;
   logic [P*D-1:0] rfm_rd_addr;
   logic [P*W-1:0] rfm_rd_data;
   logic [P-1:0]   rfm_rd_valid;
   logic           rfm_init_busy;

   modport master (
      output rfm_wr_en, rfm_wr_addr, rfm_wr_data, rfm_wr_be, rfm_rd_en, rfm_rd_addr,
      input  rfm_rd_data, rfm_rd_valid, rfm_init_busy
   );

   modport slave (
      input  rfm_wr_en, rfm_wr_addr, rfm_wr_data, rfm_wr_be, rfm_rd_en, rfm_rd_addr,
      output rfm_rd_data, rfm_rd_valid, rfm_init_busy
   );
endinterface

// File: rtl/qf_rfm_mp.sv
// Multi-read-port register-file memory with byte-enabled writes.
// After reset, an init sweep clears every entry before any access is accepted.
// The read path is either registered, with write-first bypass, or combinational, with read-before-write.
module qf_rfm_mp #(
   parameter int                          PAR_MEMORY_WIDTH_BIT = 64,
   parameter int                          PAR_MEMORY_DEPTH_BIT = 4,
   parameter int                          PAR_RD_PORTS         = 2,
   parameter int                          PAR_BYTE_WIDTH       = 8,
   parameter bit                          PAR_RD_REG           = 1'b1,
   parameter logic [PAR_MEMORY_WIDTH_BIT-1:0] PAR_INIT_VALUE   = '0
) (
   input logic          rfm_clk,
   input logic          rfm_rst,
   qf_rfm_mp_if.slave   rfm
);
   localparam int W     = PAR_MEMORY_WIDTH_BIT;
   localparam int D     = PAR_MEMORY_DEPTH_BIT;
   localparam int P     = PAR_RD_PORTS;
   localparam int BW    = PAR_BYTE_WIDTH;
   localparam int B     = W / BW;
   localparam int DEPTH = 1 << D;
   localparam logic [D-1:0] LAST_ADDR = '1;

   typedef enum logic {INIT, READY} state_t;

   state_t       state_q;
   logic [D-1:0] sweepCnt_q;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] wrMerged;
   logic [D-1:0] rdAddr [P];

   // Sequencer: reset restarts the clearing sweep, which hands over to READY after the last entry
   always_ff @(posedge rfm_clk) begin
      if (rfm_rst) begin
         state_q    <= INIT;
         sweepCnt_q <= '0;
      end else begin
         case (state_q)
            INIT: begin
               sweepCnt_q <= sweepCnt_q + 1'b1;
               if (sweepCnt_q == LAST_ADDR) begin
                  state_q <= READY;
               end
            end
            default: begin
               state_q <= READY;
            end
         endcase
      end
   end

   assign rfm.rfm_init_busy = (state_q == INIT);

   // Word seen at the write address once the enabled lanes are applied; also feeds the read bypass
   always_comb begin
      wrMerged = mem_q[rfm.rfm_wr_addr];
      for (int b = 0; b < B; b++) begin
         if (rfm.rfm_wr_be[b]) begin
            wrMerged[b*BW +: BW] = rfm.rfm_wr_data[b*BW +: BW];
         end
      end
   end

   // Unpack the per-port read addresses
   always_comb begin
      for (int p = 0; p < P; p++) begin
         rdAddr[p] = rfm.rfm_rd_addr[p*D +: D];
      end
   end

   // Storage array: the sweep writes the init value, and READY applies user writes; contents survive reset itself
   always_ff @(posedge rfm_clk) begin
      if (!rfm_rst) begin
         if (state_q == INIT) begin
            mem_q[sweepCnt_q] <= PAR_INIT_VALUE;
         end else if (rfm.rfm_wr_en) begin
            mem_q[rfm.rfm_wr_addr] <= wrMerged;
         end
      end
   end

   generate
      if (PAR_RD_REG) begin : gRegRead
         logic [W-1:0] rdData_q [P];
         logic [P-1:0] rdValid_q;

         // Registered read: capture on request, bypass a same-edge write, and hold data while idle
         always_ff @(posedge rfm_clk) begin
            if (rfm_rst) begin
               for (int p = 0; p < P; p++) begin
                  rdData_q[p] <= '0;
               end
               rdValid_q <= '0;
            end else begin
               for (int p = 0; p < P; p++) begin
                  if ((state_q == READY) && rfm.rfm_rd_en[p]) begin
                     if (rfm.rfm_wr_en && (rfm.rfm_wr_addr == rdAddr[p])) begin
                        rdData_q[p] <= wrMerged;
                     end else begin
                        rdData_q[p] <= mem_q[rdAddr[p]];
                     end
                     rdValid_q[p] <= 1'b1;
                  end else begin
                     rdValid_q[p] <= 1'b0;
                  end
               end
            end
         end

         // Pack the per-port registers onto the bus
         always_comb begin
            rfm.rfm_rd_data = '0;
            for (int p = 0; p < P; p++) begin
               rfm.rfm_rd_data[p*W +: W] = rdData_q[p];
            end
         end

         assign rfm.rfm_rd_valid = rdValid_q;
      end else begin : gCombRead
         // Combinational read: the array is presented directly, so a same-cycle write shows only after the edge
         always_comb begin
            rfm.rfm_rd_data = '0;
            for (int p = 0; p < P; p++) begin
               rfm.rfm_rd_data[p*W +: W] = mem_q[rdAddr[p]];
            end
         end

         assign rfm.rfm_rd_valid = rfm.rfm_rd_en & {P{state_q == READY}};
      end
   endgenerate
endmodule
